// File: rtl/hr_bridge_inj_arbiter_if.sv
// rtl/hr_bridge_inj_arbiter_if.sv - injection arbiter request/grant bundle
`timescale 1ns/1ps
interface hr_bridge_inj_arbiter_if #(
   parameter int NREQ = 4
);
   localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] req_i;
   logic            slot_free_i;
   logic            bfull_i;
   logic [NREQ-1:0] gnt_o;
   logic [NREQ-1:0] deQ_o;
   logic            enQ_o;
   logic [SW-1:0]   sel_o;
   logic            starve_o;

   modport master (
      output req_i, slot_free_i, bfull_i,
      input  gnt_o, deQ_o, enQ_o, sel_o, starve_o
   );

   modport slave (
      input  req_i, slot_free_i, bfull_i,
      output gnt_o, deQ_o, enQ_o, sel_o, starve_o
   );
endinterface

// File: rtl/hr_bridge_inj_arbiter.sv
// rtl/hr_bridge_inj_arbiter.sv - ring-slot injection arbiter, round-robin with starvation override
// Optional injection/stall counters are built when HR_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module hr_bridge_inj_arbiter #(
   parameter int NREQ      = 4,
   parameter int STARVE_TH = 8,
   parameter int CW        = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   hr_bridge_inj_arbiter_if.slave bus
`ifdef HR_ARB_STATS_EN
   ,
   output logic [31:0]           inj_cnt_o,
   output logic [31:0]           stall_cnt_o
`endif
);
   localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            enQ_q, enQ_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic            starve_q, starve_d;
   logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   wait_cnt_q [NREQ];
   logic [CW-1:0]   wait_cnt_d [NREQ];

   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] starved;
   logic            blocked;
   logic            st_hit;
   logic [SW-1:0]   st_idx;
   logic            rr_hit;
   logic [SW-1:0]   rr_idx;
   logic [SW-1:0]   pick;
   int              cand;

   always_comb begin
      // The last winner is masked because its FIFO's req_i still reflects the popped flit.
      elig    = bus.req_i & ~gnt_q;
      blocked = ~bus.slot_free_i | bus.bfull_i | ~(|elig);

      starved = '0;
      for (int k = 0; k < NREQ; k++) begin
         starved[k] = elig[k] && (wait_cnt_q[k] == CW'(STARVE_TH));
      end
      st_hit = |starved;
      st_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (starved[k]) begin
            st_idx = SW'(k);
         end
      end

      rr_hit = 1'b0;
      rr_idx = rr_ptr_q;
      cand   = 0;
      for (int i = 0; i < NREQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!rr_hit && elig[cand]) begin
            rr_hit = 1'b1;
            rr_idx = SW'(cand);
         end
      end

      pick     = st_hit ? st_idx : rr_idx;
      gnt_d    = '0;
      enQ_d    = 1'b0;
      sel_d    = sel_q;
      starve_d = 1'b0;
      rr_ptr_d = rr_ptr_q;
      if (!blocked) begin
         gnt_d[pick] = 1'b1;
         enQ_d       = 1'b1;
         sel_d       = pick;
         starve_d    = st_hit;
         rr_ptr_d    = (pick == SW'(NREQ - 1)) ? '0 : pick + SW'(1);
      end

      // Waiting continues to accrue while the slot or downstream buffer blocks injection.
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_d[k] || !bus.req_i[k]) begin
            wait_cnt_d[k] = '0;
         end else if (wait_cnt_q[k] != CW'(STARVE_TH)) begin
            wait_cnt_d[k] = wait_cnt_q[k] + CW'(1);
         end else begin
            wait_cnt_d[k] = wait_cnt_q[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q    <= '0;
         enQ_q    <= 1'b0;
         sel_q    <= '0;
         starve_q <= 1'b0;
         rr_ptr_q <= '0;
         for (int k = 0; k < NREQ; k++) begin
            wait_cnt_q[k] <= '0;
         end
      end else begin
         gnt_q    <= gnt_d;
         enQ_q    <= enQ_d;
         sel_q    <= sel_d;
         starve_q <= starve_d;
         rr_ptr_q <= rr_ptr_d;
         for (int k = 0; k < NREQ; k++) begin
            wait_cnt_q[k] <= wait_cnt_d[k];
         end
      end
   end

   assign bus.gnt_o    = gnt_q;
   assign bus.deQ_o    = gnt_q;
   assign bus.enQ_o    = enQ_q;
   assign bus.sel_o    = sel_q;
   assign bus.starve_o = starve_q;

`ifdef HR_ARB_STATS_EN
   logic [31:0] inj_cnt_q, inj_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        stall_now;

   always_comb begin
      stall_now   = (|bus.req_i) && (!bus.slot_free_i || bus.bfull_i);
      inj_cnt_d   = inj_cnt_q + {31'd0, enQ_q};
      stall_cnt_d = stall_cnt_q + {31'd0, stall_now};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inj_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         inj_cnt_q   <= inj_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign inj_cnt_o   = inj_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hr_bridge_inj_arbiter.sv
// tb/tb_hr_bridge_inj_arbiter.sv - scoreboard bench for the ring injection arbiter
`timescale 1ns/1ps
module tb_hr_bridge_inj_arbiter;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hr_bridge_inj_arbiter_if #(.NREQ(NREQ)) bus();

`ifdef HR_ARB_STATS_EN
   logic [31:0] inj_cnt;
   logic [31:0] stall_cnt;
`endif

   hr_bridge_inj_arbiter #(.NREQ(NREQ), .STARVE_TH(4), .CW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef HR_ARB_STATS_EN
      ,
      .inj_cnt_o   (inj_cnt),
      .stall_cnt_o (stall_cnt)
`endif
   );

   typedef struct {
      int          cyc;
      logic [3:0]  gnt;
      logic        starve;
      logic [1:0]  sel;
      int          inj;
      int          stall;
      string       name;
   } exp_t;

   exp_t       sbq[$];
   exp_t       mon_e;
   int         compared   = 0;
   int         mismatched = 0;
   int         cycle      = 0;
   int         inj_acc    = 0;
   int         stall_acc  = 0;
   logic [1:0] sel_acc    = 2'd0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] oh_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
         mon_e = sbq.pop_front();
         if (mon_e.cyc < cycle) begin
            chk({mon_e.name, "_late"}, 32'(cycle), 32'(mon_e.cyc));
         end else begin
            chk({mon_e.name, "_gnt"},    32'(bus.gnt_o),    32'(mon_e.gnt));
            chk({mon_e.name, "_deq"},    32'(bus.deQ_o),    32'(mon_e.gnt));
            chk({mon_e.name, "_enq"},    32'(bus.enQ_o),    32'(|mon_e.gnt));
            chk({mon_e.name, "_sel"},    32'(bus.sel_o),    32'(mon_e.sel));
            chk({mon_e.name, "_starve"}, 32'(bus.starve_o), 32'(mon_e.starve));
`ifdef HR_ARB_STATS_EN
            chk({mon_e.name, "_inj"},    inj_cnt,   32'(mon_e.inj));
            chk({mon_e.name, "_stall"},  stall_cnt, 32'(mon_e.stall));
`endif
         end
      end
   end

   task automatic step(input string nm, input logic [3:0] r, input logic sf, input logic bf,
                       input logic [3:0] eg, input logic es);
      exp_t e;
      bus.req_i       = r;
      bus.slot_free_i = sf;
      bus.bfull_i     = bf;
      if (eg != 4'd0) sel_acc = oh_idx(eg);
      if ((|r) && (!sf || bf)) stall_acc++;
      e.cyc    = cycle + 1;
      e.gnt    = eg;
      e.starve = es;
      e.sel    = sel_acc;
      e.inj    = inj_acc;
      e.stall  = stall_acc;
      e.name   = nm;
      sbq.push_back(e);
      if (eg != 4'd0) inj_acc++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_gnt"},    32'(bus.gnt_o),    32'd0);
      chk({nm, "_deq"},    32'(bus.deQ_o),    32'd0);
      chk({nm, "_enq"},    32'(bus.enQ_o),    32'd0);
      chk({nm, "_sel"},    32'(bus.sel_o),    32'd0);
      chk({nm, "_starve"}, 32'(bus.starve_o), 32'd0);
`ifdef HR_ARB_STATS_EN
      chk({nm, "_inj"},    inj_cnt,   32'd0);
      chk({nm, "_stall"},  stall_cnt, 32'd0);
`endif
   endtask

   // Reset is asserted between clock edges so the immediate check proves it is asynchronous.
   task automatic do_reset(input string nm);
      @(negedge clk);
      #2;
      rst             = 1'b0;
      bus.req_i       = 4'd0;
      bus.slot_free_i = 1'b1;
      bus.bfull_i     = 1'b0;
      #1;
      chk_zero({nm, "_async"});
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #2;
      rst       = 1'b1;
      inj_acc   = 0;
      stall_acc = 0;
      sel_acc   = 2'd0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req_i       = 4'd0;
      bus.slot_free_i = 1'b1;
      bus.bfull_i     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++)
         step("t1_single", 4'b0001, 1'b1, 1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0);

      do_reset("r2");
      step("t2_rr0", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
      step("t2_rr1", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0);
      step("t2_rr2", 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b0);
      step("t2_rr3", 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b0);
      step("t2_wrap", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);
      step("t2_rr5", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0);

      do_reset("r3");
      for (int i = 0; i < 5; i++) step("t3_bfull", 4'b0110, 1'b1, 1'b1, 4'b0000, 1'b0);
      step("t3_rel0", 4'b0110, 1'b1, 1'b0, 4'b0010, 1'b1);
      step("t3_rel1", 4'b0110, 1'b1, 1'b0, 4'b0100, 1'b1);
      step("t3_rel2", 4'b0110, 1'b1, 1'b0, 4'b0010, 1'b0);

      do_reset("r4");
      step("t4_first", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0);
      for (int i = 0; i < 4; i++) step("t4_hold", 4'b1010, 1'b1, 1'b1, 4'b0000, 1'b0);
      step("t4_starve1", 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1);
      step("t4_starve3", 4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1);
      step("t4_rr", 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b0);

      do_reset("r5");
      step("t5_pre", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0);
      do_reset("r5mid");
      step("t5_post", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0);

      do_reset("r6");
      for (int i = 0; i < 10; i++)
         step("t6_inj", 4'b0011, 1'b1, 1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0010, 1'b0);
      for (int i = 0; i < 3; i++) step("t6_noslot", 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0);
      step("t6_idle", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
      step("t6_idle2", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
`ifdef HR_ARB_STATS_EN
      @(negedge clk);
      chk("t6_inj_total",   inj_cnt,   32'd10);
      chk("t6_stall_total", stall_cnt, 32'd3);
`endif
      do_reset("r7");

      repeat (5) @(negedge clk);
      if (sbq.size() != 0) chk("drain", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
